// File: rtl/smem_mem_write_arbiter.sv
// smem_mem_write_arbiter: round-robin arbiter that shares the mem-queue write
// port and the mem_size/ret notification ports among NUM_LANES SMEM lanes.
// A lane keeps the grant for a whole read group (until its last beat).
// Optional per-lane accepted-beat counters: define ARB_PERF_CNT_EN.
module smem_mem_write_arbiter #(
  parameter int NUM_LANES      = 4,
  parameter int READ_NUM_WIDTH = 8,
  parameter int READ_LEN       = 101
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             stall,
  input  logic [READ_NUM_WIDTH:0]          batch_size,
  input  logic [NUM_LANES-1:0]             req_valid,
  input  logic [NUM_LANES-1:0]             req_last,
  input  logic [NUM_LANES*READ_NUM_WIDTH-1:0] req_read_num,
  input  logic [NUM_LANES*7-1:0]           req_addr,
  input  logic [NUM_LANES*256-1:0]         req_data,
  input  logic [NUM_LANES*7-1:0]           req_mem_size,
  input  logic [NUM_LANES*7-1:0]           req_ret,
  output logic [NUM_LANES-1:0]             req_ready,
  output logic                             mem_we_1,
  output logic [READ_NUM_WIDTH-1:0]        mem_read_num_1,
  output logic [6:0]                       mem_addr_1,
  output logic [255:0]                     mem_data_1,
  output logic                             mem_size_valid,
  output logic [6:0]                       mem_size,
  output logic [READ_NUM_WIDTH-1:0]        mem_size_read_num,
  output logic                             ret_valid,
  output logic [6:0]                       ret,
  output logic [READ_NUM_WIDTH-1:0]        ret_read_num,
  output logic                             batch_done,
  output logic                             err_addr,
  output logic [NUM_LANES*32-1:0]          perf_cnt
);

  localparam int RNW = READ_NUM_WIDTH;
  localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [6:0]  READ_LEN_A = 7'(READ_LEN);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     owner_q, owner_d;
  logic [LW-1:0]     rr_q, rr_d;
  logic [RNW:0]      done_cnt_q, done_cnt_d;
  logic              batch_done_q, batch_done_d;
  logic              err_addr_q, err_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [RNW-1:0]    mem_read_num_q, mem_read_num_d;
  logic [6:0]        mem_addr_q, mem_addr_d;
  logic [255:0]      mem_data_q, mem_data_d;
  logic              size_valid_q, size_valid_d;
  logic [6:0]        size_q, size_d;
  logic [RNW-1:0]    size_rn_q, size_rn_d;
  logic              ret_valid_q, ret_valid_d;
  logic [6:0]        ret_q, ret_d;
  logic [RNW-1:0]    ret_rn_q, ret_rn_d;

  logic              win_found;
  logic [LW-1:0]     win_idx;
  logic [LW-1:0]     cand;
  logic [LW-1:0]     sel_idx;
  logic              accept;
  logic              sel_last;
  logic [RNW-1:0]    sel_rn;
  logic [6:0]        sel_addr;
  logic [255:0]      sel_data;
  logic [6:0]        sel_size;
  logic [6:0]        sel_ret;
  logic              addr_bad;

  // Round-robin winner search, grant generation and selected-beat mux.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = LW'((int'(rr_q) + k) % NUM_LANES);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    sel_idx   = (state_q == LOCKED) ? owner_q : win_idx;
    req_ready = '0;
    if (!stall) begin
      if (state_q == LOCKED) req_ready[owner_q] = 1'b1;
      else if (win_found)    req_ready[win_idx] = 1'b1;
    end
    accept   = |(req_valid & req_ready);
    sel_last = req_last[sel_idx];
    sel_rn   = req_read_num[int'(sel_idx)*RNW +: RNW];
    sel_addr = req_addr[int'(sel_idx)*7 +: 7];
    sel_data = req_data[int'(sel_idx)*256 +: 256];
    sel_size = req_mem_size[int'(sel_idx)*7 +: 7];
    sel_ret  = req_ret[int'(sel_idx)*7 +: 7];
    addr_bad = (sel_addr >= READ_LEN_A);
  end

  // Grant lock, rr pointer, done counting and registered output payloads.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_d           = rr_q;
    done_cnt_d     = done_cnt_q;
    err_addr_d     = err_addr_q;
    mem_we_d       = 1'b0;
    mem_read_num_d = mem_read_num_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    size_valid_d   = 1'b0;
    size_d         = size_q;
    size_rn_d      = size_rn_q;
    ret_valid_d    = 1'b0;
    ret_d          = ret_q;
    ret_rn_d       = ret_rn_q;
    batch_done_d   = batch_done_q |
                     ((done_cnt_q == batch_size) && (batch_size != '0));
    if (accept) begin
      if (sel_last) begin
        state_d = IDLE;
        rr_d    = (sel_idx == LAST_LANE) ? '0 : sel_idx + 1'b1;
        if (done_cnt_q != '1) done_cnt_d = done_cnt_q + 1'b1;
        size_valid_d = 1'b1;
        size_d       = sel_size;
        size_rn_d    = sel_rn;
        ret_valid_d  = 1'b1;
        ret_d        = sel_ret;
        ret_rn_d     = sel_rn;
      end else begin
        state_d = LOCKED;
        owner_d = sel_idx;
      end
      if (addr_bad) err_addr_d = 1'b1;
      // Zero-size last beats and out-of-range slots never write.
      if (!addr_bad && !(sel_last && sel_size == 7'd0)) begin
        mem_we_d       = 1'b1;
        mem_read_num_d = sel_rn;
        mem_addr_d     = sel_addr;
        mem_data_d     = sel_data;
      end
    end
  end

  // State and output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      rr_q           <= '0;
      done_cnt_q     <= '0;
      batch_done_q   <= 1'b0;
      err_addr_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_read_num_q <= '0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      size_valid_q   <= 1'b0;
      size_q         <= '0;
      size_rn_q      <= '0;
      ret_valid_q    <= 1'b0;
      ret_q          <= '0;
      ret_rn_q       <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_q           <= rr_d;
      done_cnt_q     <= done_cnt_d;
      batch_done_q   <= batch_done_d;
      err_addr_q     <= err_addr_d;
      mem_we_q       <= mem_we_d;
      mem_read_num_q <= mem_read_num_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      size_valid_q   <= size_valid_d;
      size_q         <= size_d;
      size_rn_q      <= size_rn_d;
      ret_valid_q    <= ret_valid_d;
      ret_q          <= ret_d;
      ret_rn_q       <= ret_rn_d;
    end
  end

  assign mem_we_1          = mem_we_q;
  assign mem_read_num_1    = mem_read_num_q;
  assign mem_addr_1        = mem_addr_q;
  assign mem_data_1        = mem_data_q;
  assign mem_size_valid    = size_valid_q;
  assign mem_size          = size_q;
  assign mem_size_read_num = size_rn_q;
  assign ret_valid         = ret_valid_q;
  assign ret               = ret_q;
  assign ret_read_num      = ret_rn_q;
  assign batch_done        = batch_done_q;
  assign err_addr          = err_addr_q;

`ifdef ARB_PERF_CNT_EN
  logic [NUM_LANES*32-1:0] perf_q, perf_d;

  // Per-lane accepted-beat counters, wrapping at 32 bits.
  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (req_valid[i] && req_ready[i]) perf_d[i*32 +: 32] = perf_q[i*32 +: 32] + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_smem_mem_write_arbiter.sv
// Directed bench for smem_mem_write_arbiter (4 lanes, 8-bit read numbers).
module tb_smem_mem_write_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         stall;
  logic [8:0]   batch_size;
  logic [3:0]   req_valid, req_last, req_ready;
  logic [31:0]  req_read_num;
  logic [27:0]  req_addr, req_mem_size, req_ret;
  logic [1023:0] req_data;
  logic         mem_we_1, mem_size_valid, ret_valid, batch_done, err_addr;
  logic [7:0]   mem_read_num_1, mem_size_read_num, ret_read_num;
  logic [6:0]   mem_addr_1, mem_size, ret;
  logic [255:0] mem_data_1;
  logic [127:0] perf_cnt;

  int total = 0;
  int bad   = 0;

  smem_mem_write_arbiter #(.NUM_LANES(4), .READ_NUM_WIDTH(8), .READ_LEN(101)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .batch_size(batch_size),
    .req_valid(req_valid), .req_last(req_last), .req_read_num(req_read_num),
    .req_addr(req_addr), .req_data(req_data), .req_mem_size(req_mem_size),
    .req_ret(req_ret), .req_ready(req_ready), .mem_we_1(mem_we_1),
    .mem_read_num_1(mem_read_num_1), .mem_addr_1(mem_addr_1), .mem_data_1(mem_data_1),
    .mem_size_valid(mem_size_valid), .mem_size(mem_size),
    .mem_size_read_num(mem_size_read_num), .ret_valid(ret_valid), .ret(ret),
    .ret_read_num(ret_read_num), .batch_done(batch_done), .err_addr(err_addr),
    .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] lane_data(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic set_lane(input int i, input logic v, input logic l, input logic [7:0] rn,
                          input logic [6:0] a, input logic [255:0] d,
                          input logic [6:0] sz, input logic [6:0] rt);
    req_valid[i] = v;
    req_last[i]  = l;
    req_read_num[i*8 +: 8]   = rn;
    req_addr[i*7 +: 7]       = a;
    req_data[i*256 +: 256]   = d;
    req_mem_size[i*7 +: 7]   = sz;
    req_ret[i*7 +: 7]        = rt;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; batch_size = '0;
    req_valid = '0; req_last = '0; req_read_num = '0; req_addr = '0;
    req_data = '0; req_mem_size = '0; req_ret = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_we_1, mem_size_valid, ret_valid, batch_done, err_addr} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=00000",
                      {mem_we_1, mem_size_valid, ret_valid, batch_done, err_addr});
    end
    total++;
    if ({mem_addr_1, mem_read_num_1, mem_size, ret, mem_data_1} !== '0) begin
      bad++; $display("FAIL reset_payload got addr=%0d rn=%0d size=%0d ret=%0d",
                      mem_addr_1, mem_read_num_1, mem_size, ret);
    end
    total++;
    if (perf_cnt !== '0) begin bad++; $display("FAIL reset_perf got=%h want=0", perf_cnt); end
    total++;
    if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [127:0] exp_perf;
    do_reset();
    for (int i = 0; i < 4; i++)
      set_lane(i, 1'b1, 1'b1, 8'(16 + i), 7'(i), lane_data(i), 7'(i + 1), 7'(i + 2));
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (req_ready !== 4'(1 << i)) begin
        bad++; $display("FAIL rr_grant%0d got=%b want=%b", i, req_ready, 4'(1 << i));
      end
      @(posedge clk); #1;
      total++;
      if (mem_we_1 !== 1'b1 || mem_addr_1 !== 7'(i) || mem_read_num_1 !== 8'(16 + i) ||
          mem_data_1 !== lane_data(i)) begin
        bad++; $display("FAIL rr_write%0d got we=%b addr=%0d rn=%0d want we=1 addr=%0d rn=%0d",
                        i, mem_we_1, mem_addr_1, mem_read_num_1, i, 16 + i);
      end
      total++;
      if (mem_size_valid !== 1'b1 || mem_size !== 7'(i + 1) || ret_valid !== 1'b1 ||
          ret !== 7'(i + 2) || ret_read_num !== 8'(16 + i)) begin
        bad++; $display("FAIL rr_sizeret%0d got sv=%b size=%0d rv=%b ret=%0d want 1 %0d 1 %0d",
                        i, mem_size_valid, mem_size, ret_valid, ret, i + 1, i + 2);
      end
      set_lane(i, 1'b0, 1'b0, 8'd0, 7'd0, '0, 7'd0, 7'd0);
    end
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b0 || mem_size_valid !== 1'b0 || mem_addr_1 !== 7'd3) begin
      bad++; $display("FAIL rr_idle got we=%b sv=%b addr=%0d want we=0 sv=0 addr=3",
                      mem_we_1, mem_size_valid, mem_addr_1);
    end
`ifdef ARB_PERF_CNT_EN
    exp_perf = {4{32'd1}};
`else
    exp_perf = '0;
`endif
    total++;
    if (perf_cnt !== exp_perf) begin bad++; $display("FAIL rr_perf got=%h want=%h", perf_cnt, exp_perf); end
  endtask

  task automatic test_lock();
    do_reset();
    set_lane(2, 1'b1, 1'b1, 8'd22, 7'd50, lane_data(9), 7'd1, 7'd1);
    for (int b = 0; b < 3; b++) begin
      set_lane(1, 1'b1, b == 2, 8'd21, 7'(b), lane_data(b + 4), 7'd3, 7'd9);
      #1;
      total++;
      if (req_ready !== 4'b0010) begin
        bad++; $display("FAIL lock_ready%0d got=%b want=0010", b, req_ready);
      end
      @(posedge clk); #1;
      total++;
      if (mem_we_1 !== 1'b1 || mem_addr_1 !== 7'(b) || mem_read_num_1 !== 8'd21 ||
          mem_size_valid !== (b == 2)) begin
        bad++; $display("FAIL lock_beat%0d got we=%b addr=%0d rn=%0d sv=%b want we=1 addr=%0d rn=21 sv=%0d",
                        b, mem_we_1, mem_addr_1, mem_read_num_1, mem_size_valid, b, b == 2);
      end
    end
    set_lane(1, 1'b0, 1'b0, 8'd0, 7'd0, '0, 7'd0, 7'd0);
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL lock_next got=%b want=0100", req_ready); end
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b1 || mem_read_num_1 !== 8'd22 || mem_addr_1 !== 7'd50) begin
      bad++; $display("FAIL lock_lane2 got we=%b rn=%0d addr=%0d want 1 22 50",
                      mem_we_1, mem_read_num_1, mem_addr_1);
    end
    set_lane(2, 1'b0, 1'b0, 8'd0, 7'd0, '0, 7'd0, 7'd0);
  endtask

  task automatic test_stall();
    do_reset();
    set_lane(0, 1'b1, 1'b0, 8'd30, 7'd0, lane_data(0), 7'd3, 7'd4);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL stall_first got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    set_lane(0, 1'b1, 1'b0, 8'd30, 7'd1, lane_data(1), 7'd3, 7'd4);
    set_lane(2, 1'b1, 1'b1, 8'd32, 7'd9, lane_data(2), 7'd1, 7'd1);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (req_ready !== 4'b0) begin bad++; $display("FAIL stall_ready%0d got=%b want=0000", c, req_ready); end
      @(posedge clk); #1;
      total++;
      if (mem_we_1 !== 1'b0 || mem_size_valid !== 1'b0 || ret_valid !== 1'b0 || mem_addr_1 !== 7'd0) begin
        bad++; $display("FAIL stall_out%0d got we=%b sv=%b rv=%b addr=%0d want 0 0 0 0",
                        c, mem_we_1, mem_size_valid, ret_valid, mem_addr_1);
      end
    end
    stall = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL stall_resume got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b1 || mem_addr_1 !== 7'd1) begin
      bad++; $display("FAIL stall_addr1 got we=%b addr=%0d want 1 1", mem_we_1, mem_addr_1);
    end
    set_lane(0, 1'b1, 1'b1, 8'd30, 7'd2, lane_data(3), 7'd3, 7'd4);
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b1 || mem_addr_1 !== 7'd2 || mem_size_valid !== 1'b1 || mem_size_read_num !== 8'd30) begin
      bad++; $display("FAIL stall_last got we=%b addr=%0d sv=%b srn=%0d want 1 2 1 30",
                      mem_we_1, mem_addr_1, mem_size_valid, mem_size_read_num);
    end
    clear_inputs();
  endtask

  task automatic test_placeholder();
    do_reset();
    set_lane(0, 1'b1, 1'b1, 8'd7, 7'd3, lane_data(5), 7'd0, 7'd5);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL ph_ready got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b0 || mem_size_valid !== 1'b1 || mem_size !== 7'd0 || ret_valid !== 1'b1 ||
        ret !== 7'd5 || mem_size_read_num !== 8'd7 || ret_read_num !== 8'd7) begin
      bad++; $display("FAIL ph_out got we=%b sv=%b size=%0d rv=%b ret=%0d srn=%0d rrn=%0d want 0 1 0 1 5 7 7",
                      mem_we_1, mem_size_valid, mem_size, ret_valid, ret, mem_size_read_num, ret_read_num);
    end
    clear_inputs();
    @(posedge clk); #1;
    total++;
    if (mem_size_valid !== 1'b0 || ret_valid !== 1'b0 || ret !== 7'd5) begin
      bad++; $display("FAIL ph_pulse got sv=%b rv=%b ret=%0d want 0 0 5", mem_size_valid, ret_valid, ret);
    end
  endtask

  task automatic test_batch_err();
    do_reset();
    batch_size = 9'd4;
    for (int n = 0; n < 4; n++) begin
      set_lane(0, 1'b1, 1'b1, 8'(n), 7'(n), lane_data(n), 7'd1, 7'd1);
      @(posedge clk); #1;
      total++;
      if (batch_done !== 1'b0) begin bad++; $display("FAIL batch_early%0d got=%b want=0", n, batch_done); end
    end
    set_lane(0, 1'b0, 1'b0, 8'd0, 7'd0, '0, 7'd0, 7'd0);
    @(posedge clk); #1;
    total++;
    if (batch_done !== 1'b1 || err_addr !== 1'b0) begin
      bad++; $display("FAIL batch_done got done=%b err=%b want 1 0", batch_done, err_addr);
    end
    set_lane(0, 1'b1, 1'b1, 8'd9, 7'd101, lane_data(8), 7'd2, 7'd1);
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b0 || err_addr !== 1'b1 || mem_size_valid !== 1'b1 || mem_size !== 7'd2 ||
        mem_addr_1 !== 7'd3 || batch_done !== 1'b1) begin
      bad++; $display("FAIL err_addr got we=%b err=%b sv=%b size=%0d addr=%0d done=%b want 0 1 1 2 3 1",
                      mem_we_1, err_addr, mem_size_valid, mem_size, mem_addr_1, batch_done);
    end
    clear_inputs();
  endtask

  task automatic test_reset_locked();
    do_reset();
    set_lane(0, 1'b1, 1'b0, 8'd40, 7'd5, lane_data(7), 7'd2, 7'd2);
    set_lane(3, 1'b1, 1'b1, 8'd43, 7'd6, lane_data(6), 7'd1, 7'd2);
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b1 || mem_addr_1 !== 7'd5 || req_ready !== 4'b0001) begin
      bad++; $display("FAIL rl_locked got we=%b addr=%0d ready=%b want 1 5 0001", mem_we_1, mem_addr_1, req_ready);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b0 || mem_addr_1 !== 7'd0 || mem_read_num_1 !== 8'd0 || mem_data_1 !== '0) begin
      bad++; $display("FAIL rl_cleared got we=%b addr=%0d rn=%0d want 0 0 0", mem_we_1, mem_addr_1, mem_read_num_1);
    end
    reset_n = 1'b1;
    set_lane(0, 1'b0, 1'b0, 8'd0, 7'd0, '0, 7'd0, 7'd0);
    #1;
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL rl_grant3 got=%b want=1000", req_ready); end
    @(posedge clk); #1;
    total++;
    if (mem_we_1 !== 1'b1 || mem_read_num_1 !== 8'd43 || mem_addr_1 !== 7'd6) begin
      bad++; $display("FAIL rl_lane3 got we=%b rn=%0d addr=%0d want 1 43 6", mem_we_1, mem_read_num_1, mem_addr_1);
    end
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_stall();
    test_placeholder();
    test_batch_err();
    test_reset_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
